// File: rtl/priv_intr_arbiter.sv
// Interrupt pending capture, fixed-priority arbitration and trap-entry handshake.
// Optional request-to-take latency counter built when PRIV_INTR_LATENCY_CNT_EN is defined.
module priv_intr_arbiter #(
    parameter int                 NUM_SRC   = 12,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter int                 CAUSE_W   = $clog2(NUM_SRC)
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic [NUM_SRC-1:0] i_src_in,
    input  logic [NUM_SRC-1:0] i_src_clear,
    input  logic [NUM_SRC-1:0] i_mie,
    input  logic               i_global_ie,
    input  logic               i_exception,
    input  logic               i_pipe_clear,
    input  logic               i_mret,
    output logic [NUM_SRC-1:0] o_pending,
    output logic               o_intr_req,
    output logic               o_intr_take,
    output logic [CAUSE_W-1:0] o_intr_cause,
    output logic               o_in_trap,
    output logic [15:0]        o_lat_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_TAKE,
        ST_TRAP
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_SRC-1:0]   r_src_q;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   w_pending_next;
    logic [NUM_SRC-1:0]   w_take_clr;
    logic [NUM_SRC-1:0]   w_eligible;
    logic [CAUSE_W-1:0]   r_cause;
    logic [CAUSE_W-1:0]   w_winner;
    logic                 w_found;
    logic                 w_fire;
    logic                 w_arm_to_take;

    assign w_eligible = r_pending & i_mie;
    assign w_fire     = i_global_ie & (|w_eligible) & ~i_exception;

    // Edge bits: a fresh rising edge beats any clear arriving in the same cycle.
    always_comb begin
        w_take_clr     = '0;
        w_pending_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_take_clr[i] = o_intr_take && (r_cause == CAUSE_W'(i));
            if (EDGE_MASK[i]) begin
                w_pending_next[i] = (i_src_in[i] & ~r_src_q[i]) |
                                    (r_pending[i] & ~(i_src_clear[i] | w_take_clr[i]));
            end else begin
                w_pending_next[i] = i_src_in[i];
            end
        end
    end

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_eligible[i] && !w_found) begin
                w_winner = CAUSE_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_arm_to_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) w_next_state = ST_ARM;
            end
            ST_ARM: begin
                if (!i_global_ie || (w_eligible == '0)) begin
                    w_next_state = ST_IDLE;
                end else if (i_pipe_clear && !i_exception) begin
                    w_next_state  = ST_TAKE;
                    w_arm_to_take = 1'b1;
                end
            end
            ST_TAKE: w_next_state = ST_TRAP;
            ST_TRAP: begin
                if (i_mret) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state   <= ST_IDLE;
            r_src_q   <= '0;
            r_pending <= '0;
            r_cause   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_src_q   <= i_src_in;
            r_pending <= w_pending_next;
            if (w_arm_to_take) r_cause <= w_winner;
        end
    end

    assign o_pending    = r_pending;
    assign o_intr_req   = (r_state == ST_ARM);
    assign o_intr_take  = (r_state == ST_TAKE);
    assign o_in_trap    = (r_state == ST_TRAP);
    assign o_intr_cause = r_cause;

`ifdef PRIV_INTR_LATENCY_CNT_EN
    logic [15:0] r_lat_cnt;
    logic [15:0] r_lat_cycles;
    logic [15:0] w_cnt_inc;
    logic        w_idle_to_arm;

    assign w_idle_to_arm = (r_state == ST_IDLE) && (w_next_state == ST_ARM);
    assign w_cnt_inc     = (r_lat_cnt == 16'hFFFF) ? r_lat_cnt : r_lat_cnt + 16'd1;

    // The reported latency includes the ARM cycle in which the take is granted.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_lat_cnt    <= '0;
            r_lat_cycles <= '0;
        end else begin
            if (w_idle_to_arm) begin
                r_lat_cnt <= '0;
            end else if (r_state == ST_ARM) begin
                r_lat_cnt <= w_cnt_inc;
            end
            if (w_arm_to_take) r_lat_cycles <= w_cnt_inc;
        end
    end

    assign o_lat_cycles = r_lat_cycles;
`else
    assign o_lat_cycles = '0;
`endif

endmodule
